add_sub_pipe: RTL and testbench
===============================

Name: add_sub_pipe

Overview:
- Parametrised, pipelined integer adder/subtractor for the execute stage. It replaces the fixed single-cycle unsigned unit.
- The carry chain is split into STAGES equal segments, with a register stage between segments, so wide operands still meet timing.
- Supports borrow-in on subtract, a signed/unsigned flag mode and a valid/ready handshake with full backpressure.
- Produces result flags (carry/borrow, overflow, zero, negative) alongside the sum.

Parameters:
- WIDTH, 32, operand and sum width in bits. Must satisfy WIDTH % STAGES == 0.
- STAGES, 2, number of pipeline stages; also the number of carry segments. Range 1..WIDTH. Segment width SEG = WIDTH/STAGES.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  1  op_e: OP_ADD=0, OP_SUB=1
- cin  in  1  carry-in (add) / borrow-in (sub)
- signed_mode  in  1  1 selects two's-complement overflow semantics for ovf
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- sum  out  WIDTH  result
- cout  out  1  add: carry out; sub: borrow out (1 when a < b + cin unsigned)
- ovf  out  1  signed_mode=1: signed overflow; signed_mode=0: equals cout
- zero  out  1  sum == 0
- neg  out  1  sum[WIDTH-1]

Behaviour:
- Arithmetic:
  - Add: {cout,sum} = a + b + cin.
  - Sub: sum = a - b - cin, computed internally as a + ~b + !cin; cout = inverted final carry (borrow).
  - Signed overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff = op ? ~b : b.
- Pipeline:
  - Stage k (0-based) adds segment k of the operands using the carry registered from stage k-1. Stage 0 uses the effective carry-in.
  - Upper operand segments and op/signed_mode are delayed alongside the data.
  - Lower sum segments computed in earlier stages are carried forward.
  - Flags are computed combinationally from the final-stage registers.
- Latency: exactly STAGES cycles from the accept edge to out_valid=1, with no backpressure. STAGES=1 gives one cycle, matching the previous unit.
- Throughput: one operation per cycle.
- Handshake:
  - Global advance = !out_valid || out_ready. in_ready = advance.
  - When advance=0, all stage registers hold; no valid data is dropped or duplicated.
  - Empty stages (bubbles) advance along with the rest.
  - in_valid, a, b, op, cin and signed_mode are sampled only on accept.
  - The same-cycle accept and drain is legal and sustains full rate.
- Ordering: results leave in strict acceptance order.
- Reset:
  - All stage valid bits clear; out_valid=0.
  - sum, cout, ovf, neg = 0; zero reflects the cleared sum register (1) but is qualified by out_valid.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight operations with no partial output.
- Boundaries:
  - Carry rippling through every segment (e.g. 0xFFFFFFFF+1) must produce the correct result.
  - cin=1 on sub with a == b gives sum all-ones and borrow=1.
  - out_ready held low indefinitely keeps the pipeline full and stable.
  - out_valid, sum and flags must not change while out_valid && !out_ready.

Decomposition:
- Package add_sub_pkg contains:
  - typedef enum logic op_e {OP_ADD, OP_SUB};
  - typedef struct packed add_sub_flags_t {cout, ovf, zero, neg};
  - function for signed-overflow detection.
- Sub-module add_sub_seg, parametrised on SEG: one combinational segment adder with inputs a_seg, b_eff_seg and c_in, and outputs s_seg and c_out.
- add_sub_pipe instantiates STAGES copies and owns all registers and handshake logic.

Test Plan:
- WIDTH=32, STAGES=4, add a=0xFFFFFFFF, b=0, cin=1, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0x00000000, cout=1, zero=1, neg=0.
- Sub a=0, b=1, cin=0, signed_mode=1 -> sum=0xFFFFFFFF, cout=1 (borrow), ovf=0, neg=1. Sub a=5, b=5, cin=1 -> sum=0xFFFFFFFF, cout=1.
- Signed overflow: add a=0x7FFFFFFF, b=1, signed_mode=1 -> sum=0x80000000, ovf=1, cout=0. Same inputs with signed_mode=0 -> ovf=0.
- Backpressure: issue 8 back-to-back adds (a=i, b=i) and hold out_ready=0 for cycles 3..7 -> in_ready=0 while stalled, held output stable, all 8 results 2*i delivered in order with no loss.
- Reset mid-flight: accept 3 ops, assert rst for 1 cycle -> out_valid=0 next cycle and no stale result ever appears; a new op issued after reset returns after 4 cycles.
- STAGES=1 regression: random 1000 add/sub ops checked against a {1'b0,a}±{1'b0,b} reference model -> latency 1 and bit-exact {cout,sum}.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared types and overflow helper for the pipelined adder/subtractor.
package add_sub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } add_sub_flags_t;

    // Two's-complement overflow: like-signed operands yielding an opposite-signed result.
    function automatic logic signed_ovf(input logic a_msb, input logic b_eff_msb, input logic sum_msb);
        return (a_msb == b_eff_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_sub_seg.sv
// One combinational carry segment: {c_out, s_seg} = a_seg + b_eff_seg + c_in.
// Zero latency, no flow control of its own.
module add_sub_seg #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_eff_seg,
    input  logic           c_in,
    output logic [SEG-1:0] s_seg,
    output logic           c_out
);

    logic [SEG:0] total;

    always_comb begin
        total = {1'b0, a_seg} + {1'b0, b_eff_seg} + {{SEG{1'b0}}, c_in};
    end

    assign s_seg = total[SEG-1:0];
    assign c_out = total[SEG];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/sub, one carry segment per stage; latency STAGES cycles, one op per cycle.
// Whole pipeline holds when the output is valid and not consumed; in_ready mirrors that.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  logic             cin,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic adv;

    // Stage registers: operands ride along so later segments see them, sums accumulate low-to-high.
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    op_e              op_q  [STAGES];
    logic             sm_q  [STAGES];

    // Inputs presented to each stage's segment adder.
    logic             v_src  [STAGES];
    logic [WIDTH-1:0] a_src  [STAGES];
    logic [WIDTH-1:0] b_src  [STAGES];
    logic [WIDTH-1:0] s_src  [STAGES];
    logic [WIDTH-1:0] s_nxt  [STAGES];
    logic             c_src  [STAGES];
    op_e              op_src [STAGES];
    logic             sm_src [STAGES];

    logic [SEG-1:0]   seg_sum [STAGES];
    logic             seg_co  [STAGES];

    add_sub_flags_t   flags;

    assign adv      = !vld_q[LAST] || out_ready;
    assign in_ready = adv;

    always_comb begin
        v_src[0]  = in_valid;
        a_src[0]  = a;
        b_src[0]  = (op == OP_SUB) ? ~b : b;
        s_src[0]  = '0;
        c_src[0]  = (op == OP_SUB) ? ~cin : cin;
        op_src[0] = op;
        sm_src[0] = signed_mode;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k]  = vld_q[k-1];
            a_src[k]  = a_q[k-1];
            b_src[k]  = b_q[k-1];
            s_src[k]  = s_q[k-1];
            c_src[k]  = c_q[k-1];
            op_src[k] = op_q[k-1];
            sm_src[k] = sm_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        add_sub_seg #(
            .SEG(SEG)
        ) u_seg (
            .a_seg    (a_src[g][g*SEG +: SEG]),
            .b_eff_seg(b_src[g][g*SEG +: SEG]),
            .c_in     (c_src[g]),
            .s_seg    (seg_sum[g]),
            .c_out    (seg_co[g])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nxt[k]                = s_src[k];
            s_nxt[k][k*SEG +: SEG]  = seg_sum[k];
        end
    end

    // Data registers only load behind a valid token, so bubbles never disturb held values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                op_q[k]  <= OP_ADD;
                sm_q[k]  <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= v_src[k];
                if (v_src[k]) begin
                    a_q[k]  <= a_src[k];
                    b_q[k]  <= b_src[k];
                    s_q[k]  <= s_nxt[k];
                    c_q[k]  <= seg_co[k];
                    op_q[k] <= op_src[k];
                    sm_q[k] <= sm_src[k];
                end
            end
        end
    end

    // Subtract runs as a + ~b + !cin, so the final carry is the inverse of the borrow.
    always_comb begin
        flags.cout = c_q[LAST] ^ (op_q[LAST] == OP_SUB);
        flags.ovf  = sm_q[LAST] ? signed_ovf(a_q[LAST][WIDTH-1], b_q[LAST][WIDTH-1], s_q[LAST][WIDTH-1])
                                : flags.cout;
        flags.zero = (s_q[LAST] == '0);
        flags.neg  = s_q[LAST][WIDTH-1];
    end

    assign out_valid = vld_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = flags.cout;
    assign ovf       = flags.ovf;
    assign zero      = flags.zero;
    assign neg       = flags.neg;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed and random checks of add_sub_pipe at STAGES=4 and STAGES=1.
module tb_add_sub_pipe;
    import add_sub_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        p4_in_valid, p4_in_ready, p4_out_valid, p4_out_ready;
    logic [31:0] p4_a, p4_b, p4_sum;
    op_e         p4_op;
    logic        p4_cin, p4_sm, p4_cout, p4_ovf, p4_zero, p4_neg;

    logic        p1_in_valid, p1_in_ready, p1_out_valid, p1_out_ready;
    logic [31:0] p1_a, p1_b, p1_sum;
    op_e         p1_op;
    logic        p1_cin, p1_sm, p1_cout, p1_ovf, p1_zero, p1_neg;

    add_sub_pipe #(.WIDTH(32), .STAGES(4)) u_p4 (
        .clk(clk), .rst(rst),
        .in_valid(p4_in_valid), .in_ready(p4_in_ready),
        .a(p4_a), .b(p4_b), .op(p4_op), .cin(p4_cin), .signed_mode(p4_sm),
        .out_valid(p4_out_valid), .out_ready(p4_out_ready),
        .sum(p4_sum), .cout(p4_cout), .ovf(p4_ovf), .zero(p4_zero), .neg(p4_neg)
    );

    add_sub_pipe #(.WIDTH(32), .STAGES(1)) u_p1 (
        .clk(clk), .rst(rst),
        .in_valid(p1_in_valid), .in_ready(p1_in_ready),
        .a(p1_a), .b(p1_b), .op(p1_op), .cin(p1_cin), .signed_mode(p1_sm),
        .out_valid(p1_out_valid), .out_ready(p1_out_ready),
        .sum(p1_sum), .cout(p1_cout), .ovf(p1_ovf), .zero(p1_zero), .neg(p1_neg)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        op_e         op;
        logic        cin;
        logic        sm;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int issued;
        int got;
        int stale;
        logic hold_prev;
        logic [31:0] hold_sum;
        logic [32:0] e;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, OP_ADD, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001, OP_SUB, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0005, OP_SUB, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h1111_1111, OP_ADD, 1'b1, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_000A, 32'h0000_0003, OP_SUB, 1'b0, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        p4_in_valid = 1'b0; p4_a = '0; p4_b = '0; p4_op = OP_ADD; p4_cin = 1'b0; p4_sm = 1'b0; p4_out_ready = 1'b1;
        p1_in_valid = 1'b0; p1_a = '0; p1_b = '0; p1_op = OP_ADD; p1_cin = 1'b0; p1_sm = 1'b0; p1_out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid4", p4_out_valid, 0);
        chk("rst_in_ready4", p4_in_ready, 1);
        chk("rst_sum4", p4_sum, 0);
        chk("rst_cout4", p4_cout, 0);
        chk("rst_ovf4", p4_ovf, 0);
        chk("rst_neg4", p4_neg, 0);
        chk("rst_out_valid1", p1_out_valid, 0);
        chk("rst_in_ready1", p1_in_ready, 1);
        rst = 1'b0;
        tick();

        // Single operations through the 4-stage pipe with latency measurement.
        for (int i = 0; i < 9; i++) begin
            p4_a = vecs[i].a; p4_b = vecs[i].b; p4_op = vecs[i].op;
            p4_cin = vecs[i].cin; p4_sm = vecs[i].sm; p4_in_valid = 1'b1;
            tick();
            p4_in_valid = 1'b0;
            lat = 1;
            while (!p4_out_valid && lat < 20) begin
                tick();
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_sum", i), p4_sum, vecs[i].s);
            chk($sformatf("vec%0d_cout", i), p4_cout, vecs[i].co);
            chk($sformatf("vec%0d_ovf", i), p4_ovf, vecs[i].ov);
            chk($sformatf("vec%0d_zero", i), p4_zero, vecs[i].z);
            chk($sformatf("vec%0d_neg", i), p4_neg, vecs[i].n);
        end
        tick();

        // Back-to-back issue with the consumer stalled for cycles 3..7.
        issued = 0; got = 0; hold_prev = 1'b0; hold_sum = '0;
        for (int c = 0; c < 40; c++) begin
            p4_out_ready = !(c >= 3 && c <= 7);
            if (issued < 8) begin
                p4_in_valid = 1'b1; p4_a = 32'(issued); p4_b = 32'(issued);
                p4_op = OP_ADD; p4_cin = 1'b0; p4_sm = 1'b0;
            end else begin
                p4_in_valid = 1'b0;
            end
            #1;
            if (p4_out_valid && !p4_out_ready) chk("bp_in_ready_stalled", p4_in_ready, 0);
            if (hold_prev) begin
                chk("bp_hold_valid", p4_out_valid, 1);
                chk("bp_hold_sum", p4_sum, hold_sum);
            end
            hold_prev = p4_out_valid && !p4_out_ready;
            hold_sum  = p4_sum;
            if (p4_out_valid && p4_out_ready) begin
                chk($sformatf("bp_result%0d", got), p4_sum, 64'(2 * got));
                got++;
            end
            if (p4_in_valid && p4_in_ready) issued++;
            tick();
        end
        chk("bp_result_count", got, 8);
        p4_in_valid = 1'b0;
        p4_out_ready = 1'b1;
        tick();

        // Reset with three operations in flight.
        for (int j = 0; j < 3; j++) begin
            p4_in_valid = 1'b1; p4_a = 32'(100 + j); p4_b = '0; p4_op = OP_ADD; p4_cin = 1'b0;
            tick();
        end
        p4_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", p4_out_valid, 0);
        stale = 0;
        for (int j = 0; j < 8; j++) begin
            if (p4_out_valid) stale++;
            tick();
        end
        chk("midrst_no_stale", stale, 0);
        p4_a = 32'h10; p4_b = 32'h20; p4_op = OP_ADD; p4_cin = 1'b0; p4_sm = 1'b0; p4_in_valid = 1'b1;
        tick();
        p4_in_valid = 1'b0;
        lat = 1;
        while (!p4_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("postrst_latency", lat, 4);
        chk("postrst_sum", p4_sum, 32'h30);

        // Single-stage pipe against an unsigned reference, one result per cycle.
        for (int i = 0; i < 1000; i++) begin
            p1_a = $urandom; p1_b = $urandom;
            p1_op = op_e'($urandom_range(0, 1));
            p1_cin = 1'($urandom_range(0, 1));
            p1_sm = 1'($urandom_range(0, 1));
            if (p1_op == OP_ADD) e = {1'b0, p1_a} + {1'b0, p1_b} + {32'd0, p1_cin};
            else                 e = {1'b0, p1_a} - {1'b0, p1_b} - {32'd0, p1_cin};
            p1_in_valid = 1'b1;
            tick();
            chk("s1_valid", p1_out_valid, 1);
            chk("s1_result", {p1_cout, p1_sum}, e);
        end
        p1_in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
